spatz_vcfg_ctrl: RTL

Configuration controller for the Spatz vector unit. It accepts vsetvli, vsetivli and vsetvl instructions, plus CSR accesses to vstart, vl, vtype and vlenb, from the X-interface issue path. It holds the architectural vl, vtype and vstart state and drives the configuration to the lanes. It returns scalar writeback values through a 2-entry buffered result handshake.

---
 rtl/spatz_pkg.sv | 67 ++++++
 rtl/fifo_v3.sv | 68 ++++++
 rtl/spatz_vlmax_calc.sv | 80 ++++++++
 rtl/spatz_vcfg_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/spatz_pkg.sv
// ============================================================================
// Module      : spatz_pkg
// Description : Shared types and constants for the Spatz configuration
//               controller: vtype layout, SEW/LMUL encodings, CSR addresses
//               and opcodes. Fractional LMUL support is selected with the
//               SPATZ_VCFG_FRAC_LMUL_EN macro in the modules that use it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spatz_pkg;

  // Default vector register length and its size in bytes
  localparam int unsigned DEF_VLEN = 512;
  localparam int unsigned VLENB    = DEF_VLEN / 8;

  // Major opcodes and the configuration funct3 on OP-V
  localparam logic [6:0] OPC_OPV    = 7'h57;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [2:0] F3_OPCFG   = 3'b111;

  // Vector CSR addresses
  localparam logic [11:0] CSR_VSTART = 12'h008;
  localparam logic [11:0] CSR_VL     = 12'hC20;
  localparam logic [11:0] CSR_VTYPE  = 12'hC21;
  localparam logic [11:0] CSR_VLENB  = 12'hC22;

  typedef enum logic [2:0] {
    EW_8    = 3'd0,
    EW_16   = 3'd1,
    EW_32   = 3'd2,
    EW_64   = 3'd3,
    EW_128  = 3'd4,
    EW_256  = 3'd5,
    EW_512  = 3'd6,
    EW_1024 = 3'd7
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_e;

  // Architecturally visible low vtype fields plus the vill flag
  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vsew_e  vsew;
    vlmul_e vlmul;
  } vtype_t;

  // log2(SEW/LMUL) up to a constant offset; vlmul read as a signed exponent
  function automatic logic [4:0] sew_lmul_ratio(input logic [2:0] vsew,
                                                input logic [2:0] vlmul);
    return {2'b00, vsew} - {{2{vlmul[2]}}, vlmul};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_v3.sv
// ============================================================================
// Module      : fifo_v3
// Description : Small synchronous FIFO with the common_cells interface
//               (non fall-through). Output data is the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full_o  = (r_count == (AW + 1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Storage, pointers and occupancy; a flush drops all entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spatz_vlmax_calc.sv
// ============================================================================
// Module      : spatz_vlmax_calc
// Description : Combinational vtype legality check and VLMAX computation.
//               Also returns the vtype value to store (vill-only on error).
//               SPATZ_VCFG_FRAC_LMUL_EN enables mf8/mf4/mf2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spatz_vlmax_calc
  import spatz_pkg::*;
#(
  parameter int unsigned VLEN = 512,
  parameter int unsigned ELEN = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] vtype_i,
  output logic [XLEN-1:0] vtype_o,
  output logic [XLEN-1:0] vlmax_o,
  output logic            vill_o
);

  localparam logic [3:0]      MAX_VSEW   = 4'($clog2(ELEN / 8));
  localparam logic [XLEN-1:0] VLEN_W     = XLEN'(VLEN);
  localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

  vtype_t          w_vt;
  logic [2:0]      w_sew;
  logic [2:0]      w_lmul;
  logic            w_sew_bad;
  logic            w_rsvd_bad;
  logic            w_lmul_bad;
  logic [XLEN-1:0] w_per_reg;
  logic [XLEN-1:0] w_scaled;

  // A set vill bit in a vsetvl source operand also yields vill
  assign w_vt       = vtype_t'({vtype_i[XLEN-1], vtype_i[7:0]});
  assign w_sew      = w_vt.vsew;
  assign w_lmul     = w_vt.vlmul;
  assign w_sew_bad  = ({1'b0, w_sew} > MAX_VSEW);
  assign w_rsvd_bad = |vtype_i[XLEN-2:8];
  assign w_per_reg  = VLEN_W >> ({1'b0, w_sew} + 4'd3);

`ifdef SPATZ_VCFG_FRAC_LMUL_EN
  logic [2:0] w_frac_shift;
  assign w_frac_shift = 3'd0 - w_lmul;

  // Fractional LMUL is legal only while SEW still fits in ELEN*LMUL
  always_comb begin
    w_lmul_bad = 1'b0;
    if (w_lmul == LMUL_RSVD) begin
      w_lmul_bad = 1'b1;
    end else if (w_lmul[2]) begin
      w_lmul_bad = ({1'b0, w_sew} + {1'b0, w_frac_shift}) > MAX_VSEW;
    end
  end

  // Integer LMUL scales VLEN/SEW up, fractional LMUL scales it down
  always_comb begin
    w_scaled = w_lmul[2] ? (w_per_reg >> w_frac_shift) : (w_per_reg << w_lmul[1:0]);
  end
`else
  // Without fractional support every vlmul with the top bit set is illegal
  always_comb begin
    w_lmul_bad = w_lmul[2];
    w_scaled   = w_per_reg << w_lmul[1:0];
  end
`endif

  // Final legality verdict, VLMAX and the vtype value to commit
  always_comb begin
    vill_o  = w_vt.vill | w_sew_bad | w_rsvd_bad | w_lmul_bad;
    vlmax_o = vill_o ? '0 : w_scaled;
    vtype_o = vill_o ? VILL_VTYPE
                     : {{(XLEN-8){1'b0}}, w_vt.vma, w_vt.vta, w_vt.vsew, w_vt.vlmul};
  end

endmodule

`default_nettype wire

// File: rtl/spatz_vcfg_ctrl.sv
// ============================================================================
// Module      : spatz_vcfg_ctrl
// Description : Spatz configuration controller. Decodes vset{i}vl{i} and
//               vector CSR accesses from the issue path, holds vl/vtype/
//               vstart and returns scalar results through a 2-entry buffer.
//               SPATZ_VCFG_FRAC_LMUL_EN (in spatz_vlmax_calc) enables
//               fractional LMUL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spatz_vcfg_ctrl
  import spatz_pkg::*;
#(
  parameter int unsigned VLEN = 512,
  parameter int unsigned ELEN = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  output logic            issue_accept_o,
  output logic            issue_illegal_o,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [4:0]      result_rd_o,
  output logic [XLEN-1:0] result_data_o,
  output logic [XLEN-1:0] vl_o,
  output logic [XLEN-1:0] vtype_o,
  output logic [XLEN-1:0] vstart_o
);

  localparam logic [XLEN-1:0] VILL_VTYPE  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] VLENB_W     = XLEN'(VLEN / 8);
  localparam logic [XLEN-1:0] VSTART_MASK = XLEN'(VLEN - 1);

  logic [XLEN-1:0] r_vl, r_vtype, r_vstart;

  // Instruction fields
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1;
  logic [2:0]  w_f3;
  logic [11:0] w_csr;
  assign w_opcode = issue_instr_i[6:0];
  assign w_rd     = issue_instr_i[11:7];
  assign w_f3     = issue_instr_i[14:12];
  assign w_rs1    = issue_instr_i[19:15];
  assign w_csr    = issue_instr_i[31:20];

  // Decode and legality
  logic w_is_cfg, w_is_vsetvli, w_is_vsetivli, w_is_vsetvl, w_cfg_legal;
  logic w_is_csr, w_csr_write, w_csr_legal, w_fire, w_push, w_full, w_empty;
  assign w_is_cfg      = (w_opcode == OPC_OPV) && (w_f3 == F3_OPCFG);
  assign w_is_vsetvli  = w_is_cfg && !issue_instr_i[31];
  assign w_is_vsetivli = w_is_cfg && (issue_instr_i[31:30] == 2'b11);
  assign w_is_vsetvl   = w_is_cfg && (issue_instr_i[31:25] == 7'b1000000);
  assign w_cfg_legal   = w_is_vsetvli || w_is_vsetivli || w_is_vsetvl;
  assign w_is_csr      = (w_opcode == OPC_SYSTEM) && (w_f3 != 3'b000) && (w_f3 != 3'b100);
  assign w_csr_write   = (w_f3[1:0] == 2'b01) || (w_rs1 != 5'd0);
  assign w_csr_legal   = w_is_csr && ((w_csr == CSR_VSTART) ||
                         (((w_csr == CSR_VL) || (w_csr == CSR_VTYPE) || (w_csr == CSR_VLENB))
                          && !w_csr_write));

  assign issue_accept_o  = w_cfg_legal || w_csr_legal;
  assign issue_illegal_o = (w_is_cfg && !w_cfg_legal) || (w_is_csr && !w_csr_legal);
  assign issue_ready_o   = !w_full;
  assign w_fire          = issue_valid_i && issue_ready_o && issue_accept_o;
  assign w_push          = w_fire && (w_rd != 5'd0);

  // Requested vtype and AVL source per instruction form
  logic [XLEN-1:0] w_req_vtype, w_avl, w_calc_vtype, w_vlmax;
  logic            w_calc_vill;
  assign w_req_vtype = w_is_vsetvl   ? issue_rs2_i :
                       w_is_vsetivli ? XLEN'(issue_instr_i[29:20]) :
                                       XLEN'(issue_instr_i[30:20]);
  assign w_avl       = w_is_vsetivli ? XLEN'(w_rs1) : issue_rs1_i;

  spatz_vlmax_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN),
    .XLEN (XLEN)
  ) u_vlmax_calc (
    .vtype_i (w_req_vtype),
    .vtype_o (w_calc_vtype),
    .vlmax_o (w_vlmax),
    .vill_o  (w_calc_vill)
  );

  // Next vl/vtype for a vset*; rs1=rd=x0 keeps vl only if SEW/LMUL is unchanged
  logic [XLEN-1:0] w_cfg_vl, w_cfg_vtype;
  always_comb begin
    w_cfg_vl    = '0;
    w_cfg_vtype = w_calc_vtype;
    if (w_calc_vill) begin
      w_cfg_vl = '0;
    end else if (w_is_vsetivli || (w_rs1 != 5'd0)) begin
      w_cfg_vl = (w_avl < w_vlmax) ? w_avl : w_vlmax;
    end else if (w_rd != 5'd0) begin
      w_cfg_vl = w_vlmax;
    end else if (r_vtype[XLEN-1] ||
                 (sew_lmul_ratio(r_vtype[5:3], r_vtype[2:0]) !=
                  sew_lmul_ratio(w_calc_vtype[5:3], w_calc_vtype[2:0]))) begin
      w_cfg_vtype = VILL_VTYPE;
    end else begin
      w_cfg_vl = r_vl;
    end
  end

  // CSR read value and the updated vstart for a CSR write
  logic [XLEN-1:0] w_csr_old, w_csr_wdata, w_vstart_new;
  assign w_csr_wdata = w_f3[2] ? XLEN'(w_rs1) : issue_rs1_i;
  always_comb begin
    case (w_csr)
      CSR_VSTART: w_csr_old = r_vstart;
      CSR_VL:     w_csr_old = r_vl;
      CSR_VTYPE:  w_csr_old = r_vtype;
      CSR_VLENB:  w_csr_old = VLENB_W;
      default:    w_csr_old = '0;
    endcase
    case (w_f3[1:0])
      2'b01:   w_vstart_new = w_csr_wdata;
      2'b10:   w_vstart_new = r_vstart | w_csr_wdata;
      default: w_vstart_new = r_vstart & ~w_csr_wdata;
    endcase
    w_vstart_new = w_vstart_new & VSTART_MASK;
  end

  // Architectural vl/vtype/vstart, updated only on an accepted instruction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vl     <= '0;
      r_vtype  <= VILL_VTYPE;
      r_vstart <= '0;
    end else if (w_fire) begin
      if (w_cfg_legal) begin
        r_vl     <= w_cfg_vl;
        r_vtype  <= w_cfg_vtype;
        r_vstart <= '0;
      end else if ((w_csr == CSR_VSTART) && w_csr_write) begin
        r_vstart <= w_vstart_new;
      end
    end
  end

  assign vl_o     = r_vl;
  assign vtype_o  = r_vtype;
  assign vstart_o = r_vstart;

  fifo_v3 #(
    .DATA_WIDTH (XLEN + 5),
    .DEPTH      (2)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (w_full),
    .empty_o (w_empty),
    .data_i  ({w_rd, (w_cfg_legal ? w_cfg_vl : w_csr_old)}),
    .push_i  (w_push),
    .data_o  ({result_rd_o, result_data_o}),
    .pop_i   (result_ready_i)
  );

  assign result_valid_o = !w_empty;

endmodule

`default_nettype wire
